// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, reads instr_mem and hands instr+PC to decode.
// Define FETCH_LOADER_EN to add a load port that writes instr_mem while fetch is frozen.

package fetch_unit_pkg;
  localparam int unsigned XLEN = 32;

  // One fetched instruction together with the PC it was read from.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  output logic [31:0]       instr_o,
  output logic [31:0]       pc_o,
  output logic              valid_o,
  input  logic              ready_i,
`ifdef FETCH_LOADER_EN
  input  logic              load_en_i,
  input  logic              load_we_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [31:0]       load_data_i,
`endif
  output logic              misalign_o
);

  localparam int unsigned OCC_W = 2;

  fetch_entry_t      out_q;
  fetch_entry_t      skid_q;
  fetch_entry_t      resp;
  logic              valid_q;
  logic              skid_valid;
  logic              inflight;
  logic [31:0]       inflight_pc;
  logic [31:0]       pc_f;
  logic [ADDR_W-1:0] last_addr;
  logic              misalign_q;
  logic              load_active;
  logic              consume;
  logic              issue;
  logic [OCC_W-1:0]  occ;

`ifdef FETCH_LOADER_EN
  assign load_active = load_en_i & ~rst;
`else
  assign load_active = 1'b0;
`endif

  assign consume = valid_q & ready_i;
  assign resp    = {mem_rdata, inflight_pc};

  // Entries held or owed to decode after this cycle's consume; at most two may exist.
  assign occ   = OCC_W'(valid_q) + OCC_W'(skid_valid) + OCC_W'(inflight) - OCC_W'(consume);
  assign issue = ~rst & ~load_active & (occ < OCC_W'(2));

  // instr_mem request side: address holds its last value between requests.
  assign mem_ren = issue;
`ifdef FETCH_LOADER_EN
  assign mem_wen   = load_active & load_we_i;
  assign mem_wdata = load_active ? load_data_i : '0;
  assign mem_addr  = load_active ? load_addr_i : (issue ? pc_f[ADDR_W-1:0] : last_addr);
`else
  assign mem_wen   = 1'b0;
  assign mem_wdata = '0;
  assign mem_addr  = issue ? pc_f[ADDR_W-1:0] : last_addr;
`endif

  // Fetch PC, in-flight tracking, output register and skid entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f        <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      valid_q     <= 1'b0;
      out_q       <= '0;
      skid_valid  <= 1'b0;
      skid_q      <= '0;
      last_addr   <= '0;
      misalign_q  <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      if (issue) begin
        last_addr <= pc_f[ADDR_W-1:0];
      end

      if (load_active) begin
        pc_f       <= RESET_PC;
        inflight   <= 1'b0;
        valid_q    <= 1'b0;
        skid_valid <= 1'b0;
      end else if (redirect_i) begin
        // Everything fetched down the old path is dropped, including next cycle's response.
        pc_f       <= {redirect_pc_i[31:2], 2'b00};
        inflight   <= 1'b0;
        valid_q    <= 1'b0;
        skid_valid <= 1'b0;
        misalign_q <= |redirect_pc_i[1:0];
      end else begin
        if (issue) begin
          inflight    <= 1'b1;
          inflight_pc <= pc_f;
          pc_f        <= pc_f + 32'd4;
        end else begin
          inflight <= 1'b0;
        end

        if (!valid_q || consume) begin
          // Output slot frees up: the older skid entry goes first, the response backs it.
          if (skid_valid) begin
            out_q      <= skid_q;
            valid_q    <= 1'b1;
            skid_valid <= inflight;
            if (inflight) begin
              skid_q <= resp;
            end
          end else if (inflight) begin
            out_q   <= resp;
            valid_q <= 1'b1;
          end else begin
            valid_q <= 1'b0;
          end
        end else if (inflight) begin
          skid_q     <= resp;
          skid_valid <= 1'b1;
        end
      end
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = out_q.instr;
  assign pc_o       = out_q.pc;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a PC-stream model predicts every instruction decode accepts.
// Loader checks are compiled in when FETCH_LOADER_EN is defined.

module tb_fetch_unit;

  localparam int unsigned ADDR_W   = 10;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned WORDS    = 1 << (ADDR_W - 2);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              redirect_i;
  logic [31:0]       redirect_pc_i;
  logic [31:0]       instr_o;
  logic [31:0]       pc_o;
  logic              valid_o;
  logic              ready_i;
  logic              misalign_o;
  logic              loading;

`ifdef FETCH_LOADER_EN
  logic              load_en_i;
  logic              load_we_i;
  logic [ADDR_W-1:0] load_addr_i;
  logic [31:0]       load_data_i;
  assign loading = load_en_i;
`else
  assign loading = 1'b0;
`endif

  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_ren       (mem_ren),
    .mem_wen       (mem_wen),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
`ifdef FETCH_LOADER_EN
    .load_en_i     (load_en_i),
    .load_we_i     (load_we_i),
    .load_addr_i   (load_addr_i),
    .load_data_i   (load_data_i),
`endif
    .misalign_o    (misalign_o)
  );

  int          checks = 0;
  int          errors = 0;
  int          delivered = 0;
  logic [31:0] mem [WORDS];
  exp_t        exp_q [$];
  logic [31:0] stream_pc;
  logic        exp_mis;

  // Per-cycle samples taken mid-cycle by the stimulus
  logic              s_ren, s_wen, s_valid, s_mis;
  logic [ADDR_W-1:0] s_addr;
  logic [31:0]       s_wdata, s_pc, s_instr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // instr_mem: synchronous read, data the cycle after mem_ren
  initial begin
    for (int i = 0; i < int'(WORDS); i++) mem[i] = $urandom();
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h33;
    forever begin
      @(posedge clk);
      if (mem_ren) mem_rdata <= mem[mem_addr[ADDR_W-1:2]];
      if (mem_wen) mem[mem_addr[ADDR_W-1:2]] = mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return mem[pc[ADDR_W-1:2]];
  endfunction

  // Reference model: decode sees consecutive word PCs from the last restart point.
  task automatic restart(input logic [31:0] target);
    exp_q.delete();
    stream_pc = {target[31:2], 2'b00};
  endtask

  task automatic top_up();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{pc: stream_pc, instr: mem_word(stream_pc)});
      stream_pc = stream_pc + 32'd4;
    end
  endtask

  // Drive one cycle's inputs, sample mid-cycle, then apply the model after the edge.
  task automatic cycle(input logic rdy, input logic redir, input logic [31:0] tgt);
    ready_i       = rdy;
    redirect_i    = redir;
    redirect_pc_i = tgt;
    #2;
    s_ren = mem_ren;   s_wen = mem_wen;   s_addr = mem_addr; s_wdata = mem_wdata;
    s_valid = valid_o; s_pc = pc_o;       s_instr = instr_o; s_mis = misalign_o;
    @(posedge clk);
    #1;
    exp_mis = redir && (tgt[1:0] != 2'b00);
    if (redir) restart(tgt);
    top_up();
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    redirect_i = 1'b0;
    #1;
    chk("rst_valid",    32'(valid_o),    32'd0);
    chk("rst_ren",      32'(mem_ren),    32'd0);
    chk("rst_addr",     32'(mem_addr),   32'd0);
    chk("rst_instr",    instr_o,         32'd0);
    chk("rst_pc",       pc_o,            32'd0);
    chk("rst_misalign", 32'(misalign_o), 32'd0);
    chk("rst_wen",      32'(mem_wen),    32'd0);
    chk("rst_wdata",    mem_wdata,       32'd0);
    repeat (2) @(posedge clk);
    #1;
    exp_mis = 1'b0;
    restart(RESET_PC);
    top_up();
    rst = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every accepted handshake and checks cycle rules.
  initial begin
    logic prev_stall, prev_redir;
    logic [31:0] prev_instr, prev_pc;
    exp_t e;
    prev_stall = 1'b0; prev_redir = 1'b0; prev_instr = '0; prev_pc = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        prev_redir = 1'b0;
      end else begin
        chk("misalign", 32'(misalign_o), 32'(exp_mis));
`ifndef FETCH_LOADER_EN
        chk("wen_idle", {31'd0, mem_wen} | mem_wdata, 32'd0);
`endif
        if (prev_redir) chk("valid_after_redirect", 32'(valid_o), 32'd0);
        if (prev_stall) begin
          chk("stall_valid", 32'(valid_o), 32'd1);
          chk("stall_instr", instr_o, prev_instr);
          chk("stall_pc",    pc_o,    prev_pc);
        end
        if (valid_o && ready_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: actual pc %h required no delivery at %0t", pc_o, $time);
          end else begin
            e = exp_q.pop_front();
            chk("sb_pc",    pc_o,    e.pc);
            chk("sb_instr", instr_o, e.instr);
            delivered++;
          end
        end
        prev_redir = redirect_i;
        prev_stall = valid_o && !ready_i && !redirect_i && !loading;
        prev_instr = instr_o;
        prev_pc    = pc_o;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   cnt;
    logic rdy, redir;
    logic [31:0] tgt;
    rst = 1'b0; ready_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; exp_mis = 1'b0;
`ifdef FETCH_LOADER_EN
    load_en_i = 1'b0; load_we_i = 1'b0; load_addr_i = '0; load_data_i = '0;
`endif
    #2;

    // Straight-line fetch at full rate
    ready_i = 1'b1;
    do_reset();
    cycle(1'b1, 1'b0, '0);
    chk("c0_ren", 32'(s_ren), 32'd1); chk("c0_addr", 32'(s_addr), 32'd0); chk("c0_valid", 32'(s_valid), 32'd0);
    cycle(1'b1, 1'b0, '0);
    chk("c1_addr", 32'(s_addr), 32'd4); chk("c1_valid", 32'(s_valid), 32'd0);
    cycle(1'b1, 1'b0, '0);
    chk("c2_addr", 32'(s_addr), 32'd8); chk("c2_valid", 32'(s_valid), 32'd1); chk("c2_pc", s_pc, 32'd0);
    cycle(1'b1, 1'b0, '0);
    chk("c3_valid", 32'(s_valid), 32'd1); chk("c3_instr", s_instr, 32'h22);
    cycle(1'b1, 1'b0, '0);
    chk("c4_valid", 32'(s_valid), 32'd1); chk("c4_instr", s_instr, 32'h33);

    // Stall for three cycles after the first valid
    do_reset();
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, '0);
      cnt += int'(s_ren);
      chk("stall_hold_instr", s_instr, 32'h11);
    end
    chk("stall_ren_bound", 32'(cnt <= 2), 32'd1);
    chk("stall_ren_last",  32'(s_ren), 32'd0);
    cycle(1'b1, 1'b0, '0);
    chk("resume_pc0", s_pc, 32'd0);
    cycle(1'b1, 1'b0, '0);
    chk("resume_pc4", s_pc, 32'd4); chk("resume_v4", 32'(s_valid), 32'd1);
    cycle(1'b1, 1'b0, '0);
    chk("resume_pc8", s_pc, 32'd8); chk("resume_v8", 32'(s_valid), 32'd1);

    // Redirect while a request is in flight
    do_reset();
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 32'h20);
    cycle(1'b1, 1'b0, '0);
    chk("redir_valid", 32'(s_valid), 32'd0); chk("redir_addr", 32'(s_addr), 32'h20);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    chk("redir_pc", s_pc, 32'h20); chk("redir_v", 32'(s_valid), 32'd1);

    // Misaligned redirect target
    cycle(1'b1, 1'b1, 32'h22);
    cycle(1'b1, 1'b0, '0);
    chk("mis_pulse", 32'(s_mis), 32'd1); chk("mis_addr", 32'(s_addr), 32'h20);
    cycle(1'b1, 1'b0, '0);
    chk("mis_clear", 32'(s_mis), 32'd0);
    cycle(1'b1, 1'b0, '0);
    chk("mis_pc", s_pc, 32'h20);

    // Address wrap at the top of instr_mem
    cycle(1'b1, 1'b1, 32'h3FC);
    cycle(1'b1, 1'b0, '0);
    chk("wrap_addr0", 32'(s_addr), 32'h3FC);
    cycle(1'b1, 1'b0, '0);
    chk("wrap_addr1", 32'(s_addr), 32'h000);
    cycle(1'b1, 1'b0, '0);
    chk("wrap_pc0", s_pc, 32'h3FC);
    cycle(1'b1, 1'b0, '0);
    chk("wrap_pc1", s_pc, 32'h400); chk("wrap_instr1", s_instr, mem[0]);

    // Random ready/redirect traffic with mid-run resets
    for (int i = 0; i < 2000; i++) begin
      if (i == 700 || i == 1400) do_reset();
      rdy   = ($urandom_range(0, 99) < 70);
      redir = ($urandom_range(0, 99) < 6);
      tgt   = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 2047));
      cycle(rdy, redir, tgt);
    end
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, '0);
    chk("delivered_enough", 32'(delivered > 300), 32'd1);

`ifdef FETCH_LOADER_EN
    // Loader: write two words with fetch frozen, then fetch restarts from RESET_PC
    load_en_i = 1'b1; load_we_i = 1'b1; load_addr_i = ADDR_W'(4); load_data_i = 32'h13;
    cycle(1'b0, 1'b0, '0);
    chk("ld_wen0", 32'(s_wen), 32'd1); chk("ld_addr0", 32'(s_addr), 32'd4);
    chk("ld_data0", s_wdata, 32'h13);  chk("ld_ren0", 32'(s_ren), 32'd0);
    restart(RESET_PC);
    load_addr_i = '0; load_data_i = 32'h0;
    cycle(1'b0, 1'b0, '0);
    chk("ld_wen1", 32'(s_wen), 32'd1); chk("ld_addr1", 32'(s_addr), 32'd0);
    chk("ld_valid1", 32'(s_valid), 32'd0);
    restart(RESET_PC);
    load_we_i = 1'b0;
    cycle(1'b1, 1'b0, '0);
    chk("ld_wen2", 32'(s_wen), 32'd0);
    restart(RESET_PC);
    top_up();
    load_en_i = 1'b0;
    cycle(1'b1, 1'b0, '0);
    chk("ld_restart_ren", 32'(s_ren), 32'd1); chk("ld_restart_addr", 32'(s_addr), RESET_PC);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    chk("ld_first_instr", s_instr, 32'h0);
    cycle(1'b1, 1'b0, '0);
    chk("ld_second_instr", s_instr, 32'h13); chk("ld_second_pc", s_pc, RESET_PC + 32'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage; sits directly upstream of instr_mem.
- Owns the fetch PC and drives instr_mem's ren/wen/addr/data_i. Captures data_o and presents instruction+PC to decode over a valid/ready handshake.
- Supports stall (ready low), branch/jump redirect, and sustains 1 instr/cycle while decode is ready.

Parameters:
- ADDR_W, 10, instr_mem address width in bytes; mem_addr = pc[ADDR_W-1:0].
- RESET_PC, 32'h0000_0000, fetch PC after reset; must be word-aligned.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_ren  out  1  instr_mem read enable.
- mem_wen  out  1  instr_mem write enable.
- mem_addr  out  ADDR_W  instr_mem byte address.
- mem_wdata  out  32  instr_mem write data (data_i).
- mem_rdata  in  32  instr_mem read data (data_o); valid the cycle after mem_ren=1.
- redirect_i  in  1  one-cycle request to restart fetch at redirect_pc_i.
- redirect_pc_i  in  32  redirect target.
- instr_o  out  32  fetched instruction.
- pc_o  out  32  full 32-bit PC of instr_o.
- valid_o  out  1  instr_o/pc_o valid.
- ready_i  in  1  decode accepts when valid_o & ready_i.
- misalign_o  out  1  one-cycle pulse: redirect target had pc[1:0]!=0.

Behaviour:
- Reset (async assert): pc_f=RESET_PC; valid_o=0; instr_o=0; pc_o=0; mem_ren=0; mem_wen=0; mem_addr=0; mem_wdata=0; misalign_o=0; skid and in-flight flags cleared.
- First request (mem_ren=1, mem_addr=RESET_PC[ADDR_W-1:0]) is issued in the first cycle after rst deasserts. First valid_o rises 2 cycles after deassertion.
- Request pipeline: in cycle N, mem_ren=1 and addr=pc_f; inflight<=1; inflight_pc<=pc_f; pc_f<=pc_f+4 (32-bit wrap). In cycle N+1, mem_rdata belongs to inflight_pc.
- Buffering: output register plus one skid entry.
  - Response goes to the output register if it is empty or is being consumed this cycle. Otherwise it goes to the skid entry.
  - On consume, the skid entry moves into the output register.
- Issue rule: occ = valid_o + skid_valid + inflight − (valid_o & ready_i). Issue a request only when occ < 2. The skid entry can never overflow. With ready_i held at 1, throughput is 1 instr/cycle.
- While no request is issued: mem_ren=0 and mem_addr holds its previous value.
- instr_o/pc_o stay stable while valid_o & !ready_i.
- Redirect (highest priority, beats stall):
  - On the edge with redirect_i=1: valid_o<=0, skid cleared, inflight cleared. The response arriving next cycle is discarded.
  - pc_f<={redirect_pc_i[31:2],2'b00}. The new request issues in the following cycle.
  - Redirect in the same cycle as a consume: the consumed instruction counts as delivered.
  - Back-to-back redirects: the last one wins.
- Misalignment: if redirect_i & redirect_pc_i[1:0]!=0, misalign_o=1 for exactly one cycle (registered). The target is still force-aligned.
- Address wrap: mem_addr uses pc[ADDR_W-1:0] only. PC 0x400 with ADDR_W=10 fetches mem address 0, while pc_o reports 0x400.
- mem_wen=0 and mem_wdata=0 always, unless the feature below is enabled.
- Reset asserted mid-operation: all state returns to reset values immediately. In-flight data is never delivered.

Optional Feature:
- Macro: FETCH_LOADER_EN.
- With the macro: adds ports load_en_i (1), load_we_i (1), load_addr_i (ADDR_W), load_data_i (32).
  - While load_en_i=1: fetch is frozen (no requests, valid_o=0, skid and inflight cleared); mem_ren=0; mem_wen=load_we_i; mem_addr=load_addr_i; mem_wdata=load_data_i (combinational passthrough).
  - On the cycle after load_en_i falls: pc_f=RESET_PC and fetch resumes as if just out of reset.
- Without the macro: the load ports are absent; mem_wen and mem_wdata are tied to 0.

Test Plan:
- Reset, ready_i=1, mem holds 0x11,0x22,0x33 at addrs 0,4,8 → mem_addr 0,4,8 on consecutive cycles; valid_o from cycle 2; instr_o/pc_o = 0x11/0, 0x22/4, 0x33/8, one per cycle.
- Hold ready_i=0 for 3 cycles after the first valid → instr_o stays 0x11/pc_o 0; mem_ren issues at most 2 further requests then stays 0; on ready_i=1, 0x22 and 0x33 follow back-to-back with none lost or duplicated.
- redirect_i with redirect_pc_i=0x20 while a request is in flight → next valid_o has pc_o=0x20; the in-flight instruction never appears; no valid_o in the cycle after redirect.
- redirect_pc_i=0x22 → misalign_o pulses 1 cycle; fetch proceeds from 0x20.
- Redirect to 0x3FC, ADDR_W=10 → pc_o 0x3FC then 0x400; mem_addr 0x3FC then 0x000.
- (FETCH_LOADER_EN) load_en_i=1; write 0x13 at addr 4 and 0x0 at addr 0; drop load_en_i → mem_wen pulses match the writes; fetch restarts at RESET_PC; second instr_o = 0x13.
